// File: rtl/irq_state_save_ctrl.sv
// Interrupt context controller: snapshots the main FSM state into the save register,
// forces a service state, then forces the saved state back on completion or watchdog expiry.
module irq_state_save_ctrl #(
  parameter int unsigned         STATE_W       = 5,
  parameter logic [STATE_W-1:0]  SERVICE_STATE = 5'b1_1111,
  parameter int unsigned         CNT_W         = 8,
  parameter int unsigned         TIMEOUT       = 200
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Int_Req,
  input  logic [STATE_W-1:0] Cur_State,
  input  logic               Service_Done,
  input  logic [STATE_W-1:0] Saved_State,
  output logic               Save_Enable,
  output logic [STATE_W-1:0] Prev_Check_State,
  output logic               Force_Load,
  output logic [STATE_W-1:0] Force_State,
  output logic               Int_Ack,
  output logic               Busy,
  output logic               Timeout_Err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_SERVICE = 2'd2,
    S_RESTORE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               int_req_q, int_req_d;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               save_en_q, save_en_d;
  logic [STATE_W-1:0] pcs_q, pcs_d;
  logic               force_load_q, force_load_d;
  logic [STATE_W-1:0] force_state_q, force_state_d;
  logic               int_ack_q, int_ack_d;
  logic               busy_q, busy_d;
  logic               tout_q, tout_d;
  logic               rise;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      int_req_q     <= 1'b0;
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      save_en_q     <= 1'b0;
      pcs_q         <= '0;
      force_load_q  <= 1'b0;
      force_state_q <= '0;
      int_ack_q     <= 1'b0;
      busy_q        <= 1'b0;
      tout_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_req_q     <= int_req_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      save_en_q     <= save_en_d;
      pcs_q         <= pcs_d;
      force_load_q  <= force_load_d;
      force_state_q <= force_state_d;
      int_ack_q     <= int_ack_d;
      busy_q        <= busy_d;
      tout_q        <= tout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    int_req_d     = Int_Req;
    pending_d     = pending_q;
    cnt_d         = cnt_q;
    save_en_d     = save_en_q;
    pcs_d         = pcs_q;
    force_load_d  = force_load_q;
    force_state_d = force_state_q;
    int_ack_d     = int_ack_q;
    tout_d        = tout_q;
    rise          = Int_Req & ~int_req_q;

    // Requests arriving while a service is in flight collapse into one pending flag.
    if (rise && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rise || pending_q) begin
          pcs_d     = Cur_State;
          save_en_d = 1'b1;
          pending_d = 1'b0;
          state_d   = S_SAVE;
        end
      end
      S_SAVE: begin
        save_en_d     = 1'b0;
        force_load_d  = 1'b1;
        force_state_d = SERVICE_STATE;
        int_ack_d     = 1'b1;
        cnt_d         = '0;
        state_d       = S_SERVICE;
      end
      S_SERVICE: begin
        force_load_d = 1'b0;
        int_ack_d    = 1'b0;
        cnt_d        = cnt_q + CNT_W'(1);
        // Completion takes priority over a watchdog expiry on the same edge.
        if (Service_Done) begin
          force_load_d  = 1'b1;
          force_state_d = Saved_State;
          state_d       = S_RESTORE;
        end else if (cnt_q == CNT_LAST) begin
          tout_d        = 1'b1;
          force_load_d  = 1'b1;
          force_state_d = Saved_State;
          state_d       = S_RESTORE;
        end
      end
      S_RESTORE: begin
        force_load_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign Save_Enable      = save_en_q;
  assign Prev_Check_State = pcs_q;
  assign Force_Load       = force_load_q;
  assign Force_State      = force_state_q;
  assign Int_Ack          = int_ack_q;
  assign Busy             = busy_q;
  assign Timeout_Err      = tout_q;

endmodule

// File: doc/irq_state_save_ctrl.md
# irq_state_save_ctrl

Interrupt-driven context controller that sequences the 5-bit state save register of the main control FSM. On an interrupt request it captures the FSM's current state into the save unit and forces the FSM into a service state. When the service routine finishes, or a watchdog expires, it forces the FSM back to the saved state. It sits between the interrupt source, the main FSM's force-load port and the save-state register, which it drives through the Save_Enable / Prev_Check_State pair.

## Interface
Parameters:
- STATE_W, 5, width of FSM state, save data and force data
- SERVICE_STATE, 5'b1_1111, state forced into the FSM during service
- CNT_W, 8, watchdog counter width
- TIMEOUT, 200, maximum SERVICE cycles (1..2^CNT_W-1)

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- Int_Req  in  1  interrupt request; a rising edge triggers service
- Cur_State  in  STATE_W  live state of the main FSM
- Service_Done  in  1  service routine complete; level, sampled in SERVICE only
- Saved_State  in  STATE_W  read-back from the save-state register
- Save_Enable  out  1  one-cycle capture strobe to the save-state register
- Prev_Check_State  out  STATE_W  state value presented to the save-state register
- Force_Load  out  1  one-cycle strobe: main FSM loads Force_State
- Force_State  out  STATE_W  state to load into the main FSM
- Int_Ack  out  1  one-cycle acknowledge, high with the service force-load
- Busy  out  1  high in SAVE, SERVICE and RESTORE
- Timeout_Err  out  1  sticky watchdog error flag

## Operation
- All outputs are registered. Reset values: every output is 0, the FSM is in IDLE, and Int_Req_q, Pending and the counter are 0.
- Rise detect: rise = Int_Req & ~Int_Req_q, where Int_Req_q is registered every cycle.
- Pending flag: set by a rise in any state other than IDLE. Cleared when IDLE launches a save. Multiple rises collapse into one pending request.
- FSM:
  - IDLE: if rise or Pending, then Prev_Check_State <= Cur_State, Save_Enable <= 1, Pending <= 0, go to SAVE.
  - SAVE (exactly 1 cycle, Save_Enable high): Save_Enable <= 0, Force_Load <= 1, Force_State <= SERVICE_STATE, Int_Ack <= 1, counter <= 0, go to SERVICE.
  - SERVICE: Force_Load and Int_Ack drop after 1 cycle. The counter increments each cycle.
    - If Service_Done: go to RESTORE.
    - Else if counter == TIMEOUT-1: Timeout_Err <= 1, go to RESTORE.
  - RESTORE (exactly 1 cycle): Force_Load <= 1, Force_State <= Saved_State captured on entry, then go to IDLE.
- Force_State holds its last value when Force_Load is low. Prev_Check_State holds its value between saves.
- Timeout_Err is sticky and is cleared only by RST.
- Service_Done outside SERVICE is ignored.
- Counter arithmetic is unsigned CNT_W bits. It is never reached past TIMEOUT-1, so it never wraps.

## Timing
- A rise sampled at edge N (in IDLE) gives:
  - Save_Enable high in cycle N→N+1.
  - The save register updates at edge N+1.
  - Force_Load=1, Force_State=SERVICE_STATE and Int_Ack=1 in cycle N+1→N+2.
- Service_Done sampled high at edge M gives Force_Load=1 with Force_State=Saved_State in cycle M→M+1, and IDLE from edge M+1.
- Minimum service occupancy, rise to IDLE: 4 edges.
- Back-to-back: a request pending at the IDLE return starts SAVE on the next edge, so there is exactly 1 IDLE cycle between services.
- Service_Done and the timeout on the same edge: Service_Done wins and Timeout_Err is not set.
- A rise on the same edge the FSM re-enters IDLE sets Pending and is serviced on the next edge.
- Reset mid-operation: all outputs and state return to reset values immediately. Any in-flight save or restore is abandoned and no Force_Load is issued.

## Test plan
- Basic: Cur_State=5'h0A, rise at edge 10, Service_Done pulse at edge 20. Expect:
  - Save_Enable high only cycle 10–11, Prev_Check_State=5'h0A.
  - Force_Load/Int_Ack cycle 11–12 with Force_State=5'h1F.
  - Force_Load cycle 20–21 with Force_State=5'h0A.
  - Timeout_Err=0.
- Watchdog: TIMEOUT=4, Service_Done held 0. Expect RESTORE entered 4 cycles after SERVICE entry, Timeout_Err=1 and staying 1 through the next clean service.
- Pending: extra Int_Req rises (three) during SERVICE. Expect exactly one additional save sequence, starting 1 cycle after the return to IDLE.
- Tie: Service_Done=1 on the same edge the counter hits TIMEOUT-1. Expect a normal restore and Timeout_Err=0.
- Reset mid-SERVICE: RST low asynchronously between edges. Expect all outputs 0 before the next edge, IDLE after release, and no Force_Load pulse.
- Held level: Int_Req held high for 50 cycles. Expect exactly one service; Service_Done asserted while in IDLE has no effect.
